// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: enable/baud sequencing FSM, byte FIFO,
// error/overrun status and a level/status interrupt.
module uart_rx_ctrl #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic [31:0]   cfg_baud_div,
    input  logic [LW-1:0] cfg_thresh,
    input  logic          cfg_flush,
    input  logic [7:0]    rx_data_in,
    input  logic          rx_busy,
    input  logic          rx_done_tick,
    input  logic          rx_error,
    output logic          rx_en,
    output logic [31:0]   baud_div,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [LW-1:0] fifo_level,
    output logic          overrun,
    output logic [7:0]    frame_err_cnt,
    output logic [1:0]    state_o,
    output logic          irq
);
    localparam int AW = LW - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        RELOAD = 2'd3
    } state_t;

    state_t        state_q;
    logic          rx_en_q;
    logic [31:0]   baud_div_q;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          irq_q, irq_d;

    logic sampling, push_req, err_req, pop, full, push_ok;

    // Enable/divisor changes only take effect between frames: DRAIN keeps the
    // receiver running at the old divisor until rx_busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_en_q    <= 1'b0;
            baud_div_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_en) begin
                        baud_div_q <= cfg_baud_div;
                        rx_en_q    <= 1'b1;
                        state_q    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!cfg_en || (cfg_baud_div != baud_div_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rx_busy) begin
                        rx_en_q <= 1'b0;
                        state_q <= cfg_en ? RELOAD : IDLE;
                    end
                end
                RELOAD: begin
                    baud_div_q <= cfg_baud_div;
                    rx_en_q    <= 1'b1;
                    state_q    <= ACTIVE;
                end
                default: begin
                    state_q <= IDLE;
                    rx_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Read side: a byte is consumed on any cycle with rd_en=1 and rd_valid=1;
    // rd_en while rd_valid=0 is ignored and rd_data is valid only with rd_valid.
    assign sampling = (state_q == ACTIVE) || (state_q == DRAIN);
    assign push_req = sampling && rx_done_tick && !rx_error;
    assign err_req  = sampling && rx_done_tick && rx_error;
    assign pop      = rd_en && (level_q != '0);
    assign full     = (level_q == LW'(DEPTH));
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        err_cnt_d = err_cnt_q;
        if (cfg_flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            level_d   = '0;
            overrun_d = 1'b0;
            err_cnt_d = 8'd0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push_ok) level_d = level_q - LW'(1);
            if (push_req && !push_ok) overrun_d = 1'b1;
            if (err_req && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
        irq_d = ((cfg_thresh != '0) && (level_q >= cfg_thresh)) || overrun_q ||
                (err_cnt_q != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !cfg_flush && !rst) mem_q[wr_ptr_q] <= rx_data_in;
    end

    assign rd_data       = mem_q[rd_ptr_q];
    assign rd_valid      = (level_q != '0);
    assign fifo_level    = level_q;
    assign overrun       = overrun_q;
    assign frame_err_cnt = err_cnt_q;
    assign rx_en         = rx_en_q;
    assign baud_div      = baud_div_q;
    assign state_o       = state_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [31:0] cfg_baud_div;
  logic [4:0]  cfg_thresh;
  logic        cfg_flush;
  logic [7:0]  rx_data_in;
  logic        rx_busy;
  logic        rx_done_tick;
  logic        rx_error;
  logic        rx_en;
  logic [31:0] baud_div;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_level;
  logic        overrun;
  logic [7:0]  frame_err_cnt;
  logic [1:0]  state_o;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DEPTH(16), .LW(5)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_baud_div(cfg_baud_div),
    .cfg_thresh(cfg_thresh), .cfg_flush(cfg_flush), .rx_data_in(rx_data_in),
    .rx_busy(rx_busy), .rx_done_tick(rx_done_tick), .rx_error(rx_error),
    .rx_en(rx_en), .baud_div(baud_div), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_level(fifo_level), .overrun(overrun),
    .frame_err_cnt(frame_err_cnt), .state_o(state_o), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_baud_div = 32'd0; cfg_thresh = 5'd0;
    cfg_flush = 1'b0; rx_data_in = 8'd0; rx_busy = 1'b0; rx_done_tick = 1'b0;
    rx_error = 1'b0; rd_en = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_baud", baud_div, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_errcnt", 32'(frame_err_cnt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Tick in IDLE is ignored
    rx_data_in = 8'hEE; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("idle_tick_level", 32'(fifo_level), 32'd0);

    cfg_baud_div = 32'd10416; cfg_en = 1'b1;
    step();
    chk("en_state", 32'(state_o), 32'd1);
    chk("en_rx_en", 32'(rx_en), 32'd1);
    chk("en_baud", baud_div, 32'd10416);

    rx_data_in = 8'hA5; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("push_valid", 32'(rd_valid), 32'd1);
    chk("push_data", 32'(rd_data), 32'hA5);
    chk("push_level", 32'(fifo_level), 32'd1);

    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_level", 32'(fifo_level), 32'd0);
    chk("pop_valid", 32'(rd_valid), 32'd0);

    // Empty pop ignored
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_pop_level", 32'(fifo_level), 32'd0);

    rx_data_in = 8'h5A; rx_error = 1'b1; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0; rx_error = 1'b0;
    chk("ferr_level", 32'(fifo_level), 32'd0);
    chk("ferr_cnt", 32'(frame_err_cnt), 32'd1);
    chk("ferr_irq_lag", 32'(irq), 32'd0);
    step();
    chk("ferr_irq", 32'(irq), 32'd1);

    for (int i = 0; i < 17; i++) begin
      rx_data_in = 8'h10 + 8'(i); rx_done_tick = 1'b1;
      step();
    end
    rx_done_tick = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ovr", 32'(overrun), 32'd1);
    chk("full_head", 32'(rd_data), 32'h10);

    rx_data_in = 8'h77; rx_done_tick = 1'b1; rd_en = 1'b1;
    step();
    rx_done_tick = 1'b0; rd_en = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_ovr", 32'(overrun), 32'd1);
    chk("pp_head", 32'(rd_data), 32'h11);

    cfg_flush = 1'b1;
    step();
    cfg_flush = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_ovr", 32'(overrun), 32'd0);
    chk("flush_errcnt", 32'(frame_err_cnt), 32'd0);
    chk("flush_valid", 32'(rd_valid), 32'd0);
    chk("flush_state", 32'(state_o), 32'd1);
    step();
    chk("flush_irq", 32'(irq), 32'd0);

    rx_busy = 1'b1; cfg_baud_div = 32'd5208;
    step();
    chk("drain_state", 32'(state_o), 32'd2);
    chk("drain_rx_en", 32'(rx_en), 32'd1);
    chk("drain_baud", baud_div, 32'd10416);
    step();
    chk("drain_hold", 32'(state_o), 32'd2);
    rx_busy = 1'b0;
    step();
    chk("reload_state", 32'(state_o), 32'd3);
    chk("reload_rx_en", 32'(rx_en), 32'd0);
    rx_data_in = 8'h33; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    chk("reload_tick_level", 32'(fifo_level), 32'd0);
    chk("react_state", 32'(state_o), 32'd1);
    chk("react_rx_en", 32'(rx_en), 32'd1);
    chk("react_baud", baud_div, 32'd5208);

    cfg_thresh = 5'd4;
    for (int i = 0; i < 4; i++) begin
      rx_data_in = 8'h40 + 8'(i); rx_done_tick = 1'b1;
      step();
    end
    rx_done_tick = 1'b0;
    chk("th_level", 32'(fifo_level), 32'd4);
    chk("th_irq_lag", 32'(irq), 32'd0);
    step();
    chk("th_irq", 32'(irq), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("th_pop_level", 32'(fifo_level), 32'd3);
    chk("th_pop_head", 32'(rd_data), 32'h41);
    chk("th_irq_hold", 32'(irq), 32'd1);
    step();
    chk("th_irq_fall", 32'(irq), 32'd0);

    rx_busy = 1'b1; cfg_en = 1'b0;
    step();
    chk("rdrain_state", 32'(state_o), 32'd2);
    rst = 1'b1; rx_data_in = 8'h99; rx_done_tick = 1'b1;
    step();
    rst = 1'b0; rx_done_tick = 1'b0; rx_busy = 1'b0;
    chk("rdrain_idle", 32'(state_o), 32'd0);
    chk("rdrain_level", 32'(fifo_level), 32'd0);
    chk("rdrain_valid", 32'(rd_valid), 32'd0);
    chk("rdrain_rx_en", 32'(rx_en), 32'd0);
    chk("rdrain_baud", baud_div, 32'd0);
    step();
    chk("rdrain_level2", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the receive FIFO depth in bytes (power of two, 4..64).
REQ-002 The block SHALL have parameter LW, default 5, the width of the level counter (clog2(DEPTH)+1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port cfg_en, input, 1 bit: software receiver enable request.
REQ-006 The block SHALL have port cfg_baud_div, input, 32 bits: requested baud divisor.
REQ-007 The block SHALL have port cfg_thresh, input, LW bits: FIFO level interrupt threshold; 0 disables the level interrupt.
REQ-008 The block SHALL have port cfg_flush, input, 1 bit: single-cycle pulse that empties the FIFO and clears status.
REQ-009 The block SHALL have ports rx_data_in (input, 8), rx_busy (input, 1), rx_done_tick (input, 1) and rx_error (input, 1), all driven from uart_rx.
REQ-010 The block SHALL have port rx_en, output, 1 bit: receiver enable to uart_rx.
REQ-011 The block SHALL have port baud_div, output, 32 bits: applied divisor to uart_rx.
REQ-012 The block SHALL have port rd_en, input, 1 bit: pop request.
REQ-013 The block SHALL have ports rd_data (output, 8) and rd_valid (output, 1): FIFO head byte, and FIFO not empty.
REQ-014 The block SHALL have port fifo_level, output, LW bits: number of bytes stored.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is dropped because the FIFO is full.
REQ-016 The block SHALL have port frame_err_cnt, output, 8 bits: count of framing errors, saturating.
REQ-017 The block SHALL have port state_o, output, 2 bits: current FSM state encoding.
REQ-018 The block SHALL have port irq, output, 1 bit: registered interrupt.

Function
REQ-019 The FSM SHALL have four states: IDLE=0, ACTIVE=1, DRAIN=2, RELOAD=3.
REQ-020 In IDLE, rx_en SHALL be 0; when cfg_en=1, baud_div SHALL be loaded from cfg_baud_div and the FSM SHALL go to ACTIVE on the next cycle.
REQ-021 In ACTIVE, rx_en SHALL be 1; if cfg_en=0 or cfg_baud_div!=baud_div, the FSM SHALL go to DRAIN.
REQ-022 In DRAIN, rx_en SHALL stay 1 and baud_div SHALL be held; the FSM SHALL wait for rx_busy=0, then go to IDLE if cfg_en=0, else to RELOAD.
REQ-023 DRAIN SHALL never truncate a frame that is in flight.
REQ-024 In RELOAD, rx_en SHALL be 0 for exactly one cycle, baud_div SHALL be loaded from cfg_baud_div, and the FSM SHALL then go to ACTIVE.
REQ-025 The block SHALL sample rx_done_tick in ACTIVE and DRAIN only; ticks seen in IDLE or RELOAD SHALL be ignored.
REQ-026 On rx_done_tick with rx_error=0, rx_data_in SHALL be pushed; rd_valid and fifo_level SHALL update one cycle after the tick.
REQ-027 On rx_done_tick with rx_error=1, the block SHALL NOT push, and frame_err_cnt SHALL increment, saturating at 255.
REQ-028 A push to a full FIFO without a simultaneous pop SHALL drop the byte and set overrun.
REQ-029 A push and a pop in the same cycle on a full FIFO SHALL both be accepted, with fifo_level staying at DEPTH and overrun unchanged.
REQ-030 A pop SHALL occur when rd_en=1 and rd_valid=1; rd_en on an empty FIFO SHALL be ignored, and fifo_level SHALL never go below 0.
REQ-031 rd_data SHALL show the head byte combinationally from storage, and SHALL advance on the cycle after a pop.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL be exact from 0 to DEPTH.
REQ-033 cfg_flush SHALL set fifo_level=0, overrun=0 and frame_err_cnt=0 on the next cycle.
REQ-034 cfg_flush SHALL win over a same-cycle push, error increment or pop; the concurrent byte is discarded.
REQ-035 cfg_flush SHALL NOT affect the FSM.
REQ-036 irq SHALL be registered as ((cfg_thresh!=0 && fifo_level>=cfg_thresh) || overrun || frame_err_cnt!=0), using the current-cycle values.
REQ-037 irq SHALL lag its conditions by exactly one cycle.

Reset
REQ-038 While rst=1 at a clock edge, the block SHALL set: FSM=IDLE; rx_en=0; baud_div=0; pointers and fifo_level=0; rd_valid=0; overrun=0; frame_err_cnt=0; irq=0.
REQ-039 rd_data is don't-care after reset, and FIFO storage SHALL NOT need a reset.
REQ-040 Reset asserted mid-frame or mid-DRAIN SHALL abort immediately to IDLE and discard any pending rx_done_tick in that cycle.

Verification
REQ-041 The bench SHALL check: reset, then cfg_en=1 with cfg_baud_div=10416 -> the next cycle shows state ACTIVE, rx_en=1 and baud_div=10416; one tick with data 0xA5 -> rd_valid=1, rd_data=0xA5 and fifo_level=1 one cycle later; rd_en -> fifo_level=0.
REQ-042 The bench SHALL check: a tick with rx_error=1 and data 0x5A -> no push, frame_err_cnt=1, and irq=1 one cycle after the count updates.
REQ-043 The bench SHALL check: 17 good ticks with DEPTH=16 and no pops -> fifo_level=16 and overrun=1; then a push and pop in the same cycle -> level stays 16; then cfg_flush -> level 0, overrun 0, frame_err_cnt 0.
REQ-044 The bench SHALL check: with rx_busy=1 in ACTIVE, cfg_baud_div changed to 5208 -> DRAIN with baud_div held at 10416; rx_busy falls -> RELOAD with rx_en=0 for one cycle, then ACTIVE with baud_div=5208.
REQ-045 The bench SHALL check: cfg_thresh=4 with 4 pushes -> irq rises one cycle after fifo_level reaches 4; one pop -> irq falls one cycle after the level drops to 3.
REQ-046 The bench SHALL check: rst pulsed during DRAIN with a simultaneous rx_done_tick -> IDLE, fifo_level=0, and no push.
